// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle ops registered in one cycle, signed DIV/MOD via a
// fixed-latency restoring divider that stalls upstream through in_ready.
module ex_alu_unit #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [CTRL_W-1:0] control_bus,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_e,
  output logic              flag_gt,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);
  // Handshake: an op is taken on a rising edge when in_valid & in_ready & ~flush;
  // in_ready is low for the whole divide, and upstream must hold its op until taken.
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam int B_MOV = 21, B_NOT = 20, B_AND = 19, B_OR  = 18, B_ASR = 17, B_LSR = 16;
  localparam int B_LSL = 15, B_MOD = 14, B_DIV = 13, B_MUL = 12, B_CMP = 11, B_SUB = 10;
  localparam int B_ADD = 9;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem, r_quo, r_dvs, r_a_orig;
  logic              r_sa, r_neg_q, r_is_mod, r_b_zero;
  logic              r_out_valid, r_flag_e, r_flag_gt;
  logic [DATA_W-1:0] r_result;

  logic              w_busy, w_accept, w_is_div_op, w_is_cmp;
  logic [DATA_W-1:0] w_alu_res, w_abs_a, w_abs_b;
  logic [DATA_W:0]   w_rem_sh, w_trial;
  logic [DATA_W-1:0] w_quo_fix, w_rem_fix, w_div_res;
  logic              w_unused_ctrl;

  assign w_unused_ctrl = ^control_bus;
  assign w_busy        = (r_state != S_IDLE);
  assign w_accept      = in_valid & ~w_busy & ~flush;
  assign w_is_div_op   = control_bus[B_DIV] | control_bus[B_MOD];

  assign w_abs_a = op_a[DATA_W-1] ? -op_a : op_a;
  assign w_abs_b = op_b[DATA_W-1] ? -op_b : op_b;

  // One restoring step: shift in the next dividend bit, keep the trial if it did not borrow.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_sa ? -r_rem : r_rem;
  assign w_div_res = r_b_zero ? (r_is_mod ? r_a_orig : '1)
                              : (r_is_mod ? w_rem_fix : w_quo_fix);

  always_comb begin
    w_alu_res = '0;
    w_is_cmp  = 1'b0;
    if (control_bus[B_MUL])      w_alu_res = op_a * op_b;
    else if (control_bus[B_ADD]) w_alu_res = op_a + op_b;
    else if (control_bus[B_SUB]) w_alu_res = op_a - op_b;
    else if (control_bus[B_CMP]) w_is_cmp  = 1'b1;
    else if (control_bus[B_LSL]) w_alu_res = op_a << op_b[SH_W-1:0];
    else if (control_bus[B_LSR]) w_alu_res = op_a >> op_b[SH_W-1:0];
    else if (control_bus[B_ASR]) w_alu_res = DATA_W'($signed(op_a) >>> op_b[SH_W-1:0]);
    else if (control_bus[B_OR])  w_alu_res = op_a | op_b;
    else if (control_bus[B_AND]) w_alu_res = op_a & op_b;
    else if (control_bus[B_NOT]) w_alu_res = ~op_b;
    else if (control_bus[B_MOV]) w_alu_res = op_b;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_div_op) w_next_state = S_DIV;
      S_DIV:   if (flush) w_next_state = S_IDLE;
               else if (r_cnt == LAST_ITER) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_a_orig    <= '0;
      r_sa        <= 1'b0;
      r_neg_q     <= 1'b0;
      r_is_mod    <= 1'b0;
      r_b_zero    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag_e    <= 1'b0;
      r_flag_gt   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_is_div_op) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_a_orig <= op_a;
            r_sa     <= op_a[DATA_W-1];
            r_neg_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            r_is_mod <= ~control_bus[B_DIV];
            r_b_zero <= (op_b == '0);
          end else begin
            r_result    <= w_alu_res;
            r_out_valid <= 1'b1;
            if (w_is_cmp) begin
              r_flag_e  <= (op_a == op_b);
              r_flag_gt <= ($signed(op_a) > $signed(op_b));
            end
          end
        end
        S_DIV: if (!flush) begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_trial[DATA_W]) begin
            r_rem <= w_trial[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
          end
        end
        S_DONE: if (!flush) begin
          r_result    <= w_div_res;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = ~w_busy;
  assign busy        = w_busy;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign flag_e      = r_flag_e;
  assign flag_gt     = r_flag_gt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: directed vector table, divider/flush/reset sequences and a
// randomized back-to-back stream checked against an arithmetic reference model.
module tb_ex_alu_unit;
  localparam logic [21:0] C_MOV = 22'd1 << 21;
  localparam logic [21:0] C_NOT = 22'd1 << 20;
  localparam logic [21:0] C_AND = 22'd1 << 19;
  localparam logic [21:0] C_OR  = 22'd1 << 18;
  localparam logic [21:0] C_ASR = 22'd1 << 17;
  localparam logic [21:0] C_LSR = 22'd1 << 16;
  localparam logic [21:0] C_LSL = 22'd1 << 15;
  localparam logic [21:0] C_MOD = 22'd1 << 14;
  localparam logic [21:0] C_DIV = 22'd1 << 13;
  localparam logic [21:0] C_MUL = 22'd1 << 12;
  localparam logic [21:0] C_CMP = 22'd1 << 11;
  localparam logic [21:0] C_SUB = 22'd1 << 10;
  localparam logic [21:0] C_ADD = 22'd1 << 9;
  localparam logic [21:0] C_BEQ = 22'd1 << 2;
  localparam logic [21:0] C_LD  = 22'd1 << 1;
  localparam logic [21:0] SINGLE_MASK = 22'h3F9FFF;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [21:0] control_bus;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, flag_e, flag_gt, busy;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic m_e, m_gt;
  logic [31:0] exp_q[$];
  logic [1:0]  expf_q[$];

  typedef struct {
    logic [21:0] ctrl;
    logic [31:0] a, b, res;
    logic        e, gt;
  } vec_t;
  vec_t vt[22];

  ex_alu_unit #(.DATA_W(32), .CTRL_W(22)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .control_bus(control_bus), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .result(result), .flag_e(flag_e), .flag_gt(flag_gt), .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic in priority order, flags held unless CMP wins.
  task automatic model_single(input logic [21:0] c, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] res);
    logic [63:0] p;
    logic [31:0] pw;
    pw  = 32'd1 << b[4:0];
    res = 32'd0;
    if (c[12]) begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; end
    else if (c[9])  res = a + b;
    else if (c[10]) res = a - b;
    else if (c[11]) begin m_e = (a == b); m_gt = (int'(a) > int'(b)); end
    else if (c[15]) begin p = {32'd0, a} * {32'd0, pw}; res = p[31:0]; end
    else if (c[16]) res = a / pw;
    else if (c[17]) res = a[31] ? ~((~a) / pw) : a / pw;
    else if (c[18]) res = a | b;
    else if (c[19]) res = a & b;
    else if (c[20]) res = ~b;
    else if (c[21]) res = b;
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic is_mod);
    int q, r;
    if (b == 32'd0) return is_mod ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_mod ? 32'd0 : 32'h8000_0000;
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return is_mod ? 32'(r) : 32'(q);
  endfunction

  task automatic run_single(input string name, input logic [21:0] c, input logic [31:0] a,
                            input logic [31:0] b);
    logic [31:0] exp;
    model_single(c, a, b, exp);
    control_bus = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_res"}, result, exp);
    check({name, "_flags"}, {30'd0, flag_e, flag_gt}, {30'd0, m_e, m_gt});
  endtask

  task automatic run_div(input string name, input logic [21:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lowcnt;
    control_bus = c; op_a = a; op_b = b; in_valid = 1'b1;
    check({name, "_ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) break;
      lowcnt++;
      @(posedge clk); #1;
    end
    check({name, "_stall_cycles"}, 32'(lowcnt), 32'd33);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_res"}, result, exp);
    check({name, "_flags_held"}, {30'd0, flag_e, flag_gt}, {30'd0, m_e, m_gt});
    @(posedge clk); #1;
    check({name, "_valid_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b, e;
    logic        acc, isd;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; control_bus = '0; op_a = '0; op_b = '0;
    m_e = 1'b0; m_gt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, flag_e, flag_gt}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    vt[0]  = '{C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    vt[1]  = '{C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[2]  = '{C_CMP, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0};
    vt[3]  = '{C_CMP, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0};
    vt[4]  = '{C_ADD, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0};
    vt[5]  = '{C_CMP, 32'd7, 32'd3, 32'd0, 1'b0, 1'b1};
    vt[6]  = '{C_ASR, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1};
    vt[7]  = '{C_LSR, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b1};
    vt[8]  = '{C_LSL, 32'd1, 32'd35, 32'd8, 1'b0, 1'b1};
    vt[9]  = '{C_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b1};
    vt[10] = '{C_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b1};
    vt[11] = '{C_NOT, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vt[12] = '{C_MOV, 32'd9, 32'h1234, 32'h1234, 1'b0, 1'b1};
    vt[13] = '{C_MUL, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0, 1'b1};
    vt[14] = '{C_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1};
    vt[15] = '{C_ADD | C_SUB | C_MOV, 32'd10, 32'd3, 32'd13, 1'b0, 1'b1};
    vt[16] = '{C_LD | C_ADD, 32'd100, 32'd4, 32'd104, 1'b0, 1'b1};
    vt[17] = '{C_BEQ, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1};
    vt[18] = '{C_CMP | C_LSL, 32'd2, 32'd2, 32'd0, 1'b1, 1'b0};
    vt[19] = '{C_MUL | C_ADD, 32'd3, 32'd4, 32'd12, 1'b1, 1'b0};
    vt[20] = '{C_CMP, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1};
    vt[21] = '{C_CMP, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0};

    in_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      control_bus = vt[i].ctrl; op_a = vt[i].a; op_b = vt[i].b;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_res", i), result, vt[i].res);
      check($sformatf("vec%0d_flags", i), {30'd0, flag_e, flag_gt}, {30'd0, vt[i].e, vt[i].gt});
    end
    in_valid = 1'b0;
    m_e = 1'b0; m_gt = 1'b0;
    @(posedge clk); #1;
    check("idle_no_valid", 32'(out_valid), 32'd0);

    // flush wins over in_valid while idle
    flush = 1'b1; in_valid = 1'b1; control_bus = C_ADD; op_a = 32'd1; op_b = 32'd2;
    @(posedge clk); #1;
    check("flush_idle_valid", 32'(out_valid), 32'd0);
    control_bus = C_DIV;
    @(posedge clk); #1;
    check("flush_idle_div_busy", 32'(busy), 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    run_single("cmp_set", C_CMP, 32'd5, 32'd5);
    run_div("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod_m7_2", C_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div_9_0", C_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_div("mod_9_0", C_MOD, 32'd9, 32'd0, 32'd9);
    run_div("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod_ovf", C_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div_7_m2", C_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_div("mod_m100_7", C_MOD, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_div("divmod_prio", C_DIV | C_MOD | C_ADD, 32'd20, 32'd6, 32'd3);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      isd = ($urandom_range(0, 1) == 1);
      run_div($sformatf("rdiv%0d", i), isd ? C_DIV : C_MOD, a, b, ref_div(a, b, !isd));
    end

    // abort a divide with flush partway through
    control_bus = C_DIV; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_ready", 32'(in_ready), 32'd1);
    check("flush_div_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    check("flush_div_no_valid", 32'(pulses), 32'd0);
    run_single("after_flush_add", C_ADD, 32'd20, 32'd22);

    // randomized back-to-back stream with gaps and occasional flush
    for (int i = 0; i < 250; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      control_bus = 22'($urandom) & SINGLE_MASK;
      op_a = $urandom;
      op_b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) op_b = op_a;
      acc = in_valid & ~flush;
      if (acc) begin
        model_single(control_bus, op_a, op_b, e);
        exp_q.push_back(e);
        expf_q.push_back({m_e, m_gt});
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'(acc));
      if (acc && exp_q.size() > 0) begin
        check($sformatf("rnd%0d_res", i), result, exp_q.pop_front());
        check($sformatf("rnd%0d_flags", i), {30'd0, flag_e, flag_gt}, {30'd0, expf_q.pop_front()});
      end
    end
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a divide
    run_single("pre_rst_cmp", C_CMP, 32'd8, 32'd8);
    run_single("pre_rst_add", C_ADD, 32'd1, 32'd2);
    control_bus = C_DIV; op_a = 32'd50; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_div_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_flags", {30'd0, flag_e, flag_gt}, 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_e = 1'b0; m_gt = 1'b0;
    @(posedge clk); #1;
    run_single("post_rst_add", C_ADD, 32'd40, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
